// File: rtl/gat_pkg.sv
// gat_pkg: shared state type, defaults and helpers for the GAT layer sequencing blocks
package gat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        CLR,
        RUN,
        PDONE,
        DONE,
        ERR
    } spmm_sched_state_t;

    localparam int SPMM_NUM_NODES_DEF  = 13264;
    localparam int SPMM_MAX_PASSES_DEF = 8;
    localparam int SPMM_TIMEOUT_DEF    = 4096;

    function automatic int clamp_cfg(input int val, input int lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/spmm_watchdog.sv
// spmm_watchdog: counts enabled cycles since the last clear and flags when the limit is hit
module spmm_watchdog
    import gat_pkg::*;
#(
    parameter int TIMEOUT_CYC = SPMM_TIMEOUT_DEF,
    parameter int TMO_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    // saturating idle-cycle counter; a clear or a disabled cycle restarts it
    always_ff @(posedge clk) begin
        if (!rst_n || clr || !en) cnt <= '0;
        else if (cnt != TMO_W'(TIMEOUT_CYC)) cnt <= cnt + 1'b1;
    end

    // a clear in the same cycle suppresses expiry so a late write still counts as progress
    assign expired = en && !clr && (cnt >= TMO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/spmm_scheduler.sv
// spmm_scheduler: sequences weight load, engine clear and row streaming over multiple passes
module spmm_scheduler
    import gat_pkg::*;
#(
    parameter int NUM_OF_NODES_TOTAL = SPMM_NUM_NODES_DEF,
    parameter int MAX_PASSES         = SPMM_MAX_PASSES_DEF,
    parameter int TIMEOUT_CYC        = SPMM_TIMEOUT_DEF,
    parameter int ROW_CNT_W          = $clog2(NUM_OF_NODES_TOTAL + 1),
    parameter int PASS_W             = $clog2(MAX_PASSES + 1),
    parameter int TMO_W              = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [ROW_CNT_W-1:0] num_rows_i,
    input  logic [PASS_W-1:0]    num_passes_i,
    output logic                 w_load_start_o,
    input  logic                 w_load_done_i,
    output logic                 spmm_rst_n_o,
    output logic                 spmm_valid_o,
    input  logic                 wh_wea_i,
    output logic [ROW_CNT_W-1:0] wh_row_cnt_o,
    output logic [PASS_W-1:0]    pass_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    spmm_sched_state_t    state;
    logic [ROW_CNT_W-1:0] cfg_rows;
    logic [ROW_CNT_W-1:0] row_cnt;
    logic [PASS_W-1:0]    cfg_passes;
    logic [PASS_W-1:0]    pass_idx;
    logic                 clr_q;
    logic                 clr_hold;
    logic                 err_q;
    logic                 done_q;
    logic                 wls_q;
    logic                 run;
    logic                 tmo;

    assign run = (state == RUN);

    spmm_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TMO_W      (TMO_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run),
        .clr    (wh_wea_i),
        .expired(tmo)
    );

    // job sequencer: state, latched config, row/pass counters and one-cycle strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cfg_rows   <= '0;
            cfg_passes <= '0;
            row_cnt    <= '0;
            pass_idx   <= '0;
            clr_q      <= 1'b0;
            clr_hold   <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            wls_q      <= 1'b0;
        end else begin
            wls_q  <= 1'b0;
            done_q <= 1'b0;
            clr_q  <= 1'b0;
            if (abort_i && state != IDLE) begin
                state <= IDLE;
                clr_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            cfg_rows   <= ROW_CNT_W'(clamp_cfg(int'(num_rows_i), NUM_OF_NODES_TOTAL));
                            cfg_passes <= PASS_W'(clamp_cfg(int'(num_passes_i), MAX_PASSES));
                            pass_idx   <= '0;
                            row_cnt    <= '0;
                            err_q      <= 1'b0;
                            if (num_rows_i == '0 || num_passes_i == '0) begin
                                state <= DONE;
                            end else begin
                                state <= WLOAD;
                                wls_q <= 1'b1;
                            end
                        end
                    end
                    WLOAD: begin
                        if (w_load_done_i) begin
                            state    <= CLR;
                            clr_q    <= 1'b1;
                            clr_hold <= 1'b1;
                        end
                    end
                    CLR: begin
                        row_cnt <= '0;
                        if (clr_hold) begin
                            clr_hold <= 1'b0;
                            clr_q    <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (wh_wea_i) begin
                            row_cnt <= row_cnt + 1'b1;
                            if (row_cnt + 1'b1 >= cfg_rows) state <= PDONE;
                        end else if (tmo) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                    PDONE: begin
                        if (pass_idx + 1'b1 < cfg_passes) begin
                            pass_idx <= pass_idx + 1'b1;
                            state    <= WLOAD;
                            wls_q    <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                    ERR:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign w_load_start_o = wls_q;
    assign spmm_rst_n_o   = rst_n & ~clr_q;
    assign spmm_valid_o   = run;
    assign wh_row_cnt_o   = row_cnt;
    assign pass_idx_o     = pass_idx;
    assign busy_o         = (state != IDLE);
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_spmm_scheduler.sv
// tb_spmm_scheduler: job-level self-checking bench for spmm_scheduler
module tb_spmm_scheduler;

    localparam int ROW_W  = 14;
    localparam int PASS_W = 4;
    localparam int TMO    = 16;
    localparam int NONE   = 1000;
    localparam int BUDGET = 4000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [ROW_W-1:0]  num_rows_i = '0;
    logic [PASS_W-1:0] num_passes_i = '0;
    logic              w_load_start_o;
    logic              w_load_done_i = 1'b0;
    logic              spmm_rst_n_o;
    logic              spmm_valid_o;
    logic              wh_wea_i = 1'b0;
    logic [ROW_W-1:0]  wh_row_cnt_o;
    logic [PASS_W-1:0] pass_idx_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spmm_scheduler #(.TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .num_rows_i    (num_rows_i),
        .num_passes_i  (num_passes_i),
        .w_load_start_o(w_load_start_o),
        .w_load_done_i (w_load_done_i),
        .spmm_rst_n_o  (spmm_rst_n_o),
        .spmm_valid_o  (spmm_valid_o),
        .wh_wea_i      (wh_wea_i),
        .wh_row_cnt_o  (wh_row_cnt_o),
        .pass_idx_o    (pass_idx_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    // stimulus fields, then expected job outcome
    typedef struct {
        int rows, passes, ld, gap, stall, abort_at;
        int wls, done, err, cnt, valid, rstlow;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // job outcome from the rules: whole-job arithmetic, no cycle-level state
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        if (v.rows == 0 || v.passes == 0) begin
            e.wls = 0; e.done = 1; e.err = 0; e.cnt = 0; e.valid = 0; e.rstlow = 0;
        end else if (v.abort_at < v.rows) begin
            e.wls = 1; e.done = 0; e.err = 0; e.cnt = v.abort_at;
            e.valid = (v.abort_at + 1) * v.gap; e.rstlow = 3;
        end else if (v.stall < v.rows) begin
            e.wls = 1; e.done = 0; e.err = 1; e.cnt = v.stall;
            e.valid = v.stall * v.gap + TMO; e.rstlow = 2;
        end else begin
            e.wls = v.passes; e.done = 1; e.err = 0; e.cnt = v.rows;
            e.valid = v.passes * v.rows * v.gap; e.rstlow = 2 * v.passes;
        end
        return e;
    endfunction

    // drive one job like the loader/engine would, with stray start/wea noise, and score it
    task automatic run_job(input vec_t v, input string tag);
        int  wls = 0, dn = 0, errf = 0, vcyc = 0, rstlow = 0, pbad = 0, lbad = 0;
        int  ld_at = -100, ld_cnt = 0, g = 0, sent = 0;
        bit  ld_pend = 0, prev_v = 0, ended = 0;
        @(negedge clk);
        start_i      = 1'b1;
        num_rows_i   = ROW_W'(v.rows);
        num_passes_i = PASS_W'(v.passes);
        @(negedge clk);
        start_i = 1'b0;
        check({tag, ".busy_after_start"}, int'(busy_o), 1);
        check({tag, ".wls_after_start"}, int'(w_load_start_o), (v.rows != 0 && v.passes != 0) ? 1 : 0);
        check({tag, ".err_cleared"}, int'(err_o), 0);
        for (int cyc = 0; cyc < BUDGET && !ended; cyc++) begin
            if (w_load_start_o) begin
                if (int'(pass_idx_o) != wls) pbad++;
                wls++;
                ld_pend = 1; ld_cnt = v.ld; sent = 0; g = 0;
            end
            if (spmm_valid_o) begin
                vcyc++;
                if (!prev_v && cyc - ld_at != 3) lbad++;
            end
            prev_v = spmm_valid_o;
            if (done_o) dn++;
            if (!spmm_rst_n_o) rstlow++;
            if (err_o) errf = 1;
            w_load_done_i = 1'b0; wh_wea_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
            if (!busy_o) begin
                ended = 1;
            end else begin
                if (ld_pend) begin
                    if (ld_cnt == 0) begin
                        w_load_done_i = 1'b1; ld_pend = 0; ld_at = cyc;
                    end else ld_cnt--;
                end
                if (spmm_valid_o) begin
                    g++;
                    if (g == v.gap) begin
                        if (wls == 1 && sent == v.abort_at) abort_i = 1'b1;
                        else if (!(wls == 1 && sent >= v.stall)) begin
                            wh_wea_i = 1'b1; sent++; g = 0;
                        end
                    end
                end else begin
                    wh_wea_i = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 7) == 0) begin
                    start_i      = 1'b1;
                    num_rows_i   = ROW_W'($urandom);
                    num_passes_i = PASS_W'($urandom);
                end
                @(negedge clk);
            end
        end
        w_load_done_i = 1'b0; wh_wea_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
        check({tag, ".terminated"}, int'(ended), 1);
        check({tag, ".wls_pulses"}, wls, v.wls);
        check({tag, ".done_pulses"}, dn, v.done);
        check({tag, ".err"}, errf, v.err);
        check({tag, ".row_cnt"}, int'(wh_row_cnt_o), v.cnt);
        check({tag, ".valid_cycles"}, vcyc, v.valid);
        check({tag, ".spmm_rst_low"}, rstlow, v.rstlow);
        check({tag, ".pass_idx_seq_bad"}, pbad, 0);
        check({tag, ".load_to_valid_bad"}, lbad, 0);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t rv;
        int   mode;
        bit   got;
        tbl[0] = '{5, 1, 10, 16, NONE, NONE, 1, 1, 0, 5, 80, 2};
        tbl[1] = '{4, 3, 3, 2, NONE, NONE, 3, 1, 0, 4, 24, 6};
        tbl[2] = '{0, 2, 0, 1, NONE, NONE, 0, 1, 0, 0, 0, 0};
        tbl[3] = '{3, 0, 0, 1, NONE, NONE, 0, 1, 0, 0, 0, 0};
        tbl[4] = '{6, 2, 2, 3, 2, NONE, 1, 0, 1, 2, 22, 2};
        tbl[5] = '{6, 1, 1, 2, NONE, 3, 1, 0, 0, 3, 8, 3};
        tbl[6] = '{1, 1, 0, 1, NONE, NONE, 1, 1, 0, 1, 1, 2};
        tbl[7] = '{2, 8, 0, 1, NONE, NONE, 8, 1, 0, 2, 16, 16};
        tbl[8] = '{3, 1, 0, 1, 0, NONE, 1, 0, 1, 0, 16, 2};
        tbl[9] = '{4, 2, 5, 3, NONE, 0, 1, 0, 0, 0, 3, 3};

        // reset values
        repeat (3) @(negedge clk);
        check("rst.spmm_rst_n", int'(spmm_rst_n_o), 0);
        check("rst.busy", int'(busy_o), 0);
        check("rst.valid", int'(spmm_valid_o), 0);
        check("rst.done", int'(done_o), 0);
        check("rst.err", int'(err_o), 0);
        check("rst.wls", int'(w_load_start_o), 0);
        check("rst.row_cnt", int'(wh_row_cnt_o), 0);
        check("rst.pass_idx", int'(pass_idx_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel.spmm_rst_n", int'(spmm_rst_n_o), 1);

        // abort while idle is a no-op
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("idle_abort.busy", int'(busy_o), 0);
        check("idle_abort.spmm_rst_n", int'(spmm_rst_n_o), 1);

        for (int i = 0; i < 10; i++) run_job(tbl[i], $sformatf("tbl%0d", i));

        // error flag is sticky until the next accepted start
        run_job(tbl[8], "sticky_src");
        repeat (3) @(negedge clk);
        check("sticky.err", int'(err_o), 1);
        run_job(tbl[6], "sticky_clr");

        // abort during weight load
        start_i = 1'b1; num_rows_i = ROW_W'(3); num_passes_i = PASS_W'(1);
        @(negedge clk);
        start_i = 1'b0;
        check("wl_abort.wls", int'(w_load_start_o), 1);
        repeat (2) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("wl_abort.busy", int'(busy_o), 0);
        check("wl_abort.spmm_rst_n", int'(spmm_rst_n_o), 0);
        check("wl_abort.done", int'(done_o), 0);
        @(negedge clk);
        check("wl_abort.spmm_rst_n_after", int'(spmm_rst_n_o), 1);

        for (int i = 0; i < 25; i++) begin
            rv = '{0, 0, 0, 0, NONE, NONE, 0, 0, 0, 0, 0, 0};
            rv.rows   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            rv.passes = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            rv.ld     = int'($urandom_range(0, 6));
            rv.gap    = int'($urandom_range(1, 5));
            mode      = int'($urandom_range(0, 3));
            if (mode == 1 && rv.rows > 0) rv.stall = int'($urandom_range(0, rv.rows - 1));
            if (mode == 2 && rv.rows > 0) rv.abort_at = int'($urandom_range(0, rv.rows - 1));
            run_job(model(rv), $sformatf("rnd%0d", i));
        end

        // reset asserted mid-run
        @(negedge clk);
        start_i = 1'b1; num_rows_i = ROW_W'(5); num_passes_i = PASS_W'(2);
        @(negedge clk);
        start_i = 1'b0;
        w_load_done_i = 1'b1;
        @(negedge clk);
        w_load_done_i = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (spmm_valid_o) got = 1;
            else @(negedge clk);
        end
        check("midrst.reached_run", int'(got), 1);
        wh_wea_i = 1'b1;
        repeat (2) @(negedge clk);
        wh_wea_i = 1'b0;
        check("midrst.row_cnt_before", int'(wh_row_cnt_o), 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.valid", int'(spmm_valid_o), 0);
        check("midrst.busy", int'(busy_o), 0);
        check("midrst.row_cnt", int'(wh_row_cnt_o), 0);
        check("midrst.spmm_rst_n", int'(spmm_rst_n_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.spmm_rst_n_rel", int'(spmm_rst_n_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
